// File: rtl/calc_pkg.sv
// Shared types for the calculator keypad sequencer: FSM states, display
// mux codes, key priority encoding and the state-to-display mapping.
package calc_pkg;

  typedef enum logic [3:0] {
    S_START,
    S_OP_A,
    S_OP_A_NEG,
    S_OPRND,
    S_OP_B,
    S_OP_B_NEG,
    S_EXEC,
    S_RESULT,
    S_ERROR
  } state_e;

  localparam logic [1:0] DISP_A   = 2'b00;
  localparam logic [1:0] DISP_B   = 2'b01;
  localparam logic [1:0] DISP_RES = 2'b10;
  localparam logic [1:0] DISP_ERR = 2'b11;

  // Winning key after priority resolution; higher enum value = higher priority.
  typedef enum logic [2:0] {
    KEY_NONE,
    KEY_DIG,
    KEY_MR,
    KEY_BKSP,
    KEY_SUB,
    KEY_OP,
    KEY_EX,
    KEY_CLEAR
  } key_e;

  // Resolve coincident key pulses: clear > ex > op > sub > bksp > mr > dig.
  function automatic key_e key_winner(input logic clear_k, input logic ex_k,
                                      input logic op_k, input logic sub_k,
                                      input logic bksp_k, input logic mr_k,
                                      input logic dig_k);
    key_e k;
    if (clear_k)     k = KEY_CLEAR;
    else if (ex_k)   k = KEY_EX;
    else if (op_k)   k = KEY_OP;
    else if (sub_k)  k = KEY_SUB;
    else if (bksp_k) k = KEY_BKSP;
    else if (mr_k)   k = KEY_MR;
    else if (dig_k)  k = KEY_DIG;
    else             k = KEY_NONE;
    return k;
  endfunction

  // Which register the display shows in each state. EXEC still shows B so
  // the result appears exactly when RESULT is entered.
  function automatic logic [1:0] disp_of(input state_e s);
    logic [1:0] d;
    case (s)
      S_OPRND, S_OP_B, S_OP_B_NEG, S_EXEC: d = DISP_B;
      S_RESULT:                            d = DISP_RES;
      S_ERROR:                             d = DISP_ERR;
      default:                             d = DISP_A;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/calc_digit_counter.sv
// Saturating digit counter shared by both operands. Priority within a cycle:
// clear > load > inc > dec. Never wraps at 0 or MAX_DIGITS.
module calc_digit_counter #(
  parameter int MAX_DIGITS = 4,
  parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q >= MAX_CNT);

  // Next count: clear, clamped load, or saturating step.
  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (load_i)
      count_d = (load_val_i > MAX_CNT) ? MAX_CNT : load_val_i;
    else if (inc_i && !full_o)
      count_d = count_q + CNT_W'(1);
    else if (dec_i && !empty_o)
      count_d = count_q - CNT_W'(1);
  end

  // Count register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/calc_sequencer.sv
// Keypad control FSM for the calculator datapath. Strobes are Mealy outputs
// decoded from the registered state and the winning key pulse; display select
// and error flag are registered from the next state.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int MEM_SLOTS  = 4,
  localparam int SLOT_W    = (MEM_SLOTS > 1) ? $clog2(MEM_SLOTS) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              dig_in,
  input  logic              sub_in,
  input  logic              op_in,
  input  logic              ex_in,
  input  logic              bksp_in,
  input  logic              clear_in,
  input  logic              ms_in,
  input  logic              mr_in,
  input  logic              mc_in,
  input  logic [SLOT_W-1:0] slot_sel,
  input  logic              err_in,
  output logic              load_A,
  output logic              load_B,
  output logic              bksp_A,
  output logic              bksp_B,
  output logic              load_op,
  output logic              execute,
  output logic              recall_A,
  output logic              recall_B,
  output logic              load_mem,
  output logic              clear_mem,
  output logic [SLOT_W-1:0] mem_slot,
  output logic              chain,
  output logic              reset_out,
  output logic              error,
  output logic [1:0]        display_select
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  state_e     state_q, state_d;
  logic [1:0] disp_q;
  logic       error_q;

  key_e       key;
  logic       on_b;
  state_e     empty_st, entry_st, neg_st;

  // Operand-agnostic strobes, steered to A or B by on_b.
  logic ld_s, bk_s, rc_s, op_s, exe_s, chain_s, rst_s;

  logic             cnt_clr, cnt_ld, cnt_inc, cnt_dec;
  logic [CNT_W-1:0] cnt_ld_val;
  logic [CNT_W-1:0] cnt_count;
  logic             cnt_empty, cnt_full;
  logic             mem_ok;

  calc_digit_counter #(
    .MAX_DIGITS(MAX_DIGITS),
    .CNT_W     (CNT_W)
  ) u_digit_counter (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear_i   (cnt_clr),
    .load_i    (cnt_ld),
    .load_val_i(cnt_ld_val),
    .inc_i     (cnt_inc),
    .dec_i     (cnt_dec),
    .count_o   (cnt_count),
    .empty_o   (cnt_empty),
    .full_o    (cnt_full)
  );

  // Next state, counter control and strobe decode from the winning key.
  always_comb begin
    state_d    = state_q;
    ld_s       = 1'b0;
    bk_s       = 1'b0;
    rc_s       = 1'b0;
    op_s       = 1'b0;
    exe_s      = 1'b0;
    chain_s    = 1'b0;
    rst_s      = 1'b0;
    cnt_clr    = 1'b0;
    cnt_ld     = 1'b0;
    cnt_ld_val = '0;
    cnt_inc    = 1'b0;
    cnt_dec    = 1'b0;

    key      = key_winner(clear_in, ex_in, op_in, sub_in, bksp_in, mr_in, dig_in);
    on_b     = state_q inside {S_OPRND, S_OP_B, S_OP_B_NEG};
    empty_st = on_b ? S_OPRND    : S_START;
    entry_st = on_b ? S_OP_B     : S_OP_A;
    neg_st   = on_b ? S_OP_B_NEG : S_OP_A_NEG;

    if (key == KEY_CLEAR) begin
      rst_s   = 1'b1;
      cnt_clr = 1'b1;
      state_d = S_START;
    end else begin
      case (state_q)
        S_START, S_OPRND: begin
          // Only an idle START clears the datapath; OPRND keeps A and op.
          rst_s = !on_b;
          case (key)
            KEY_DIG: begin
              ld_s       = 1'b1;
              rst_s      = 1'b0;
              cnt_ld     = 1'b1;
              cnt_ld_val = CNT_ONE;
              state_d    = entry_st;
            end
            KEY_SUB: begin
              ld_s    = 1'b1;
              rst_s   = 1'b0;
              state_d = neg_st;
            end
            KEY_MR: begin
              rc_s       = 1'b1;
              rst_s      = 1'b0;
              cnt_ld     = 1'b1;
              cnt_ld_val = CNT_MAX;
              state_d    = entry_st;
            end
            default: ;
          endcase
        end
        S_OP_A, S_OP_B: begin
          case (key)
            KEY_DIG: begin
              ld_s    = !cnt_full;
              cnt_inc = 1'b1;
            end
            KEY_BKSP: begin
              bk_s    = 1'b1;
              cnt_dec = 1'b1;
              if (cnt_empty || cnt_count == CNT_ONE) state_d = empty_st;
            end
            KEY_MR: begin
              rc_s       = 1'b1;
              cnt_ld     = 1'b1;
              cnt_ld_val = CNT_MAX;
            end
            KEY_OP: begin
              if (!on_b) begin
                op_s    = 1'b1;
                cnt_clr = 1'b1;
                state_d = S_OPRND;
              end
            end
            KEY_EX: begin
              if (on_b) begin
                exe_s   = 1'b1;
                state_d = S_EXEC;
              end
            end
            default: ;
          endcase
        end
        S_OP_A_NEG, S_OP_B_NEG: begin
          case (key)
            KEY_SUB, KEY_BKSP: begin
              bk_s    = 1'b1;
              state_d = empty_st;
            end
            KEY_DIG: begin
              ld_s       = 1'b1;
              cnt_ld     = 1'b1;
              cnt_ld_val = CNT_ONE;
              state_d    = entry_st;
            end
            KEY_MR: begin
              rc_s       = 1'b1;
              cnt_ld     = 1'b1;
              cnt_ld_val = CNT_MAX;
              state_d    = entry_st;
            end
            default: ;
          endcase
        end
        S_EXEC: begin
          state_d = err_in ? S_ERROR : S_RESULT;
        end
        S_RESULT: begin
          // Chaining: result becomes A and the new operator is latched together.
          if (key == KEY_OP) begin
            chain_s = 1'b1;
            op_s    = 1'b1;
            cnt_clr = 1'b1;
            state_d = S_OPRND;
          end
        end
        S_ERROR: ;
        default: begin
          cnt_clr = 1'b1;
          state_d = S_START;
        end
      endcase
    end
  end

  // State register with registered display select and error flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_START;
      disp_q  <= DISP_A;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_of(state_d);
      error_q <= (state_d == S_ERROR);
    end
  end

  assign mem_ok = (state_q != S_ERROR) && (state_q != S_EXEC);

  // Strobes are forced low while reset is held, independent of key inputs.
  assign load_A    = reset_n & ld_s & ~on_b;
  assign load_B    = reset_n & ld_s &  on_b;
  assign bksp_A    = reset_n & bk_s & ~on_b;
  assign bksp_B    = reset_n & bk_s &  on_b;
  assign recall_A  = reset_n & rc_s & ~on_b;
  assign recall_B  = reset_n & rc_s &  on_b;
  assign load_op   = reset_n & op_s;
  assign execute   = reset_n & exe_s;
  assign chain     = reset_n & chain_s;
  assign reset_out = reset_n & rst_s;
  assign load_mem  = reset_n & ms_in & mem_ok;
  assign clear_mem = reset_n & mc_in & mem_ok;
  assign mem_slot  = slot_sel;

  assign display_select = disp_q;
  assign error          = error_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: each stimulus cycle pushes the expected
// output vector; a monitor on the falling edge pops and compares.
module tb_calc_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       dig_in, sub_in, op_in, ex_in, bksp_in, clear_in;
  logic       ms_in, mr_in, mc_in;
  logic [1:0] slot_sel;
  logic       err_in;
  logic       load_A, load_B, bksp_A, bksp_B, load_op, execute;
  logic       recall_A, recall_B, load_mem, clear_mem, chain, reset_out, error;
  logic [1:0] mem_slot;
  logic [1:0] display_select;

  always #5 clock = ~clock;

  calc_sequencer #(
    .MAX_DIGITS(4),
    .MEM_SLOTS (4)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .dig_in        (dig_in),
    .sub_in        (sub_in),
    .op_in         (op_in),
    .ex_in         (ex_in),
    .bksp_in       (bksp_in),
    .clear_in      (clear_in),
    .ms_in         (ms_in),
    .mr_in         (mr_in),
    .mc_in         (mc_in),
    .slot_sel      (slot_sel),
    .err_in        (err_in),
    .load_A        (load_A),
    .load_B        (load_B),
    .bksp_A        (bksp_A),
    .bksp_B        (bksp_B),
    .load_op       (load_op),
    .execute       (execute),
    .recall_A      (recall_A),
    .recall_B      (recall_B),
    .load_mem      (load_mem),
    .clear_mem     (clear_mem),
    .mem_slot      (mem_slot),
    .chain         (chain),
    .reset_out     (reset_out),
    .error         (error),
    .display_select(display_select)
  );

  // Observed output vector, MSB to LSB.
  logic [16:0] obs;
  assign obs = {load_A, load_B, bksp_A, bksp_B, load_op, execute, recall_A, recall_B,
                load_mem, clear_mem, chain, reset_out, error, display_select, mem_slot};

  localparam logic [16:0] LA  = 17'h10000;
  localparam logic [16:0] LB  = 17'h08000;
  localparam logic [16:0] BA  = 17'h04000;
  localparam logic [16:0] BB  = 17'h02000;
  localparam logic [16:0] LOP = 17'h01000;
  localparam logic [16:0] EXE = 17'h00800;
  localparam logic [16:0] RA  = 17'h00400;
  localparam logic [16:0] LM  = 17'h00100;
  localparam logic [16:0] CM  = 17'h00080;
  localparam logic [16:0] CH  = 17'h00040;
  localparam logic [16:0] RO  = 17'h00020;
  localparam logic [16:0] ER  = 17'h00010;
  localparam logic [16:0] DA  = 17'h00000;
  localparam logic [16:0] DB  = 17'h00004;
  localparam logic [16:0] DR  = 17'h00008;
  localparam logic [16:0] DE  = 17'h0000C;

  // Key vector: {mc, mr, ms, clear, bksp, ex, op, sub, dig}
  localparam logic [8:0] K0   = 9'h000;
  localparam logic [8:0] KDIG = 9'h001;
  localparam logic [8:0] KSUB = 9'h002;
  localparam logic [8:0] KOP  = 9'h004;
  localparam logic [8:0] KEX  = 9'h008;
  localparam logic [8:0] KBK  = 9'h010;
  localparam logic [8:0] KCLR = 9'h020;
  localparam logic [8:0] KMS  = 9'h040;
  localparam logic [8:0] KMR  = 9'h080;
  localparam logic [8:0] KMC  = 9'h100;

  logic [16:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [16:0] mon_e;
  string       mon_n;

  // Drive one key cycle just after the rising edge and queue its expected outputs.
  task automatic step(input string nm, input logic [8:0] k, input logic [1:0] slot,
                      input logic err, input logic [16:0] e);
    @(posedge clock);
    #1;
    {mc_in, mr_in, ms_in, clear_in, bksp_in, ex_in, op_in, sub_in, dig_in} = k;
    slot_sel = slot;
    err_in   = err;
    exp_q.push_back({e[16:2], slot});
    name_q.push_back(nm);
  endtask

  task automatic direct_check(input string nm, input logic [16:0] e);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, obs, e);
    end else begin
      $display("ok   %s: %h", nm, obs);
    end
  endtask

  // Monitor: compare the DUT outputs mid-cycle against the queued expectation.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      checks++;
      if (obs !== mon_e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", mon_n, obs, mon_e);
      end else begin
        $display("ok   %s: %h", mon_n, obs);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    {mc_in, mr_in, ms_in, clear_in, bksp_in, ex_in, op_in, sub_in, dig_in} = K0;
    slot_sel = 2'd0;
    err_in   = 1'b0;
    #2;
    direct_check("reset_hold", 17'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Idle START after release, then digit limit.
    step("idle_after_reset", K0,   2'd0, 1'b0, RO | DA);
    step("a_dig1",           KDIG, 2'd0, 1'b0, LA);
    step("a_dig2",           KDIG, 2'd0, 1'b0, LA);
    step("a_dig3",           KDIG, 2'd0, 1'b0, LA);
    step("a_dig4",           KDIG, 2'd0, 1'b0, LA);
    step("a_dig5_ignored",   KDIG, 2'd0, 1'b0, DA);
    step("a_clear",          KCLR, 2'd0, 1'b0, RO);
    step("start_idle",       K0,   2'd0, 1'b0, RO);

    // Backspace to empty returns to START.
    step("bk_dig",           KDIG, 2'd0, 1'b0, LA);
    step("bk_bksp",          KBK,  2'd0, 1'b0, BA);
    step("bk_start_idle",    K0,   2'd0, 1'b0, RO);

    // Full operation, result display latency, chaining.
    step("op_a_dig",         KDIG, 2'd0, 1'b0, LA);
    step("op_op",            KOP,  2'd0, 1'b0, LOP);
    step("op_b_dig",         KDIG, 2'd0, 1'b0, LB | DB);
    step("op_ex",            KEX,  2'd0, 1'b0, EXE | DB);
    step("op_exec_cycle",    K0,   2'd0, 1'b0, DB);
    step("op_result",        K0,   2'd0, 1'b0, DR);
    step("res_dig_ignored",  KDIG, 2'd0, 1'b0, DR);
    step("res_ex_ignored",   KEX,  2'd0, 1'b0, DR);
    step("res_chain",        KOP,  2'd0, 1'b0, CH | LOP | DR);
    step("oprnd_idle",       K0,   2'd0, 1'b0, DB);
    step("oprnd_sub",        KSUB, 2'd0, 1'b0, LB | DB);
    step("bneg_ex_ignored",  KEX,  2'd0, 1'b0, DB);
    step("bneg_bksp",        KBK,  2'd0, 1'b0, BB | DB);
    step("oprnd_mc_slot3",   KMC,  2'd3, 1'b0, CM | DB);
    step("oprnd_clear",      KCLR, 2'd0, 1'b0, RO | DB);
    step("start_idle2",      K0,   2'd0, 1'b0, RO);

    // Error path.
    step("er_a_dig",         KDIG, 2'd0, 1'b0, LA);
    step("er_op",            KOP,  2'd0, 1'b0, LOP);
    step("er_b_dig",         KDIG, 2'd0, 1'b0, LB | DB);
    step("er_ex",            KEX,  2'd0, 1'b0, EXE | DB);
    step("er_exec_err1",     K0,   2'd0, 1'b1, DB);
    step("er_idle",          K0,   2'd0, 1'b0, ER | DE);
    step("er_dig_ignored",   KDIG, 2'd0, 1'b0, ER | DE);
    step("er_ms_ignored",    KMS,  2'd1, 1'b0, ER | DE);
    step("er_clear",         KCLR, 2'd0, 1'b0, RO | ER | DE);
    step("er_start_idle",    K0,   2'd0, 1'b0, RO);

    // Memory store / recall on slot 2; recall fills the operand.
    step("m_dig",            KDIG, 2'd0, 1'b0, LA);
    step("m_ms_slot2",       KMS,  2'd2, 1'b0, LM);
    step("m_clear",          KCLR, 2'd0, 1'b0, RO);
    step("m_mr_slot2",       KMR,  2'd2, 1'b0, RA);
    step("m_full_dig_ign",   KDIG, 2'd0, 1'b0, DA);
    step("m_bksp",           KBK,  2'd0, 1'b0, BA);
    step("m_dig_after_bk",   KDIG, 2'd0, 1'b0, LA);
    step("m_clear2",         KCLR, 2'd0, 1'b0, RO);

    // Clear beats a coincident digit.
    step("cd_dig",           KDIG, 2'd0, 1'b0, LA);
    step("cd_clear_dig",     KCLR | KDIG, 2'd0, 1'b0, RO);
    step("cd_start_idle",    K0,   2'd0, 1'b0, RO);

    // Asynchronous reset in the middle of OP_B.
    step("ar_a_dig",         KDIG, 2'd0, 1'b0, LA);
    step("ar_op",            KOP,  2'd0, 1'b0, LOP);
    step("ar_b_dig",         KDIG, 2'd0, 1'b0, LB | DB);
    @(posedge clock);
    #1;
    {mc_in, mr_in, ms_in, clear_in, bksp_in, ex_in, op_in, sub_in, dig_in} = KDIG;
    #1;
    direct_check("ar_pre_reset_dig", LB | DB);
    reset_n = 1'b0;
    #1;
    direct_check("ar_async_reset", 17'h0);
    {mc_in, mr_in, ms_in, clear_in, bksp_in, ex_in, op_in, sub_in, dig_in} = K0;
    @(posedge clock);
    #1;
    direct_check("ar_reset_held", 17'h0);
    @(negedge clock);
    reset_n = 1'b1;
    step("ar_idle_after",    K0,   2'd0, 1'b0, RO);

    @(posedge clock);
    #1;
    {mc_in, mr_in, ms_in, clear_in, bksp_in, ex_in, op_in, sub_in, dig_in} = K0;
    repeat (3) @(posedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
